arbiter_rr_pkt_n: RTL and testbench
===================================

Name: arbiter_rr_pkt_n

Overview:
Parametrised N-input round-robin arbiter with valid/ready handshakes on every port and packet-aware grant locking: a granted input keeps the grant until it delivers its last beat. The output is registered through a 2-entry skid buffer, so downstream ready does not reach input ready combinationally. Each output beat carries the index of its source input. It is used where several DMA or stream producers share one downstream channel.

Parameters:
- DWIDTH, 20, width of the data beat.
- N, 2, number of input channels (N >= 1).
- LOCK_PKT, 1, 1 = grant held until in_last beat; 0 = re-arbitrate after every beat.
- SRCW, (N>1 ? $clog2(N) : 1), width of out_src (derived; do not override).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1 x [N]  per-input valid (unpacked array).
- in_data  in  DWIDTH x [N]  per-input data (unpacked array).
- in_last  in  1 x [N]  per-input last-beat-of-packet flag.
- in_ready  out  1 x [N]  per-input ready.
- out_valid  out  1  output beat valid.
- out_data  out  DWIDTH  output data.
- out_last  out  1  last flag of the output beat.
- out_src  out  SRCW  index of the input that supplied the beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - All in_ready=0.
  - FSM=IDLE, priority pointer ptr=0, skid buffer count=0.
- Transfer rules:
  - An input beat transfers when in_valid[i] & in_ready[i].
  - An output beat transfers when out_valid & out_ready.
  - in_valid must not depend on in_ready.
- Skid buffer:
  - 2-entry FIFO holding {data, last, src}. buf_ready = (count < 2), registered.
  - out_valid = (count > 0); out_* come from the head entry.
  - Latency: an input transfer in cycle t gives out_valid=1 in cycle t+1.
  - Full throughput (one beat/cycle) while out_ready stays 1.
  - Simultaneous push and pop keeps count unchanged.
  - out_ready=0 with count=2 forces buf_ready=0, so all in_ready=0.
- Grant selection (combinational):
  - IDLE: g = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - LOCKED: g = lock_id.
  - in_ready[i] = buf_ready & (i == g) & (IDLE ? in_valid[i] : 1).
  - At most one in_ready is high in any cycle.
  - No valid input in IDLE: all in_ready=0.
- FSM states IDLE, LOCKED:
  - IDLE, transfer from g with in_last=1, or LOCK_PKT=0: stay IDLE, ptr <= (g+1) mod N.
  - IDLE, transfer from g with in_last=0 and LOCK_PKT=1: go LOCKED, lock_id <= g; ptr unchanged.
  - LOCKED, transfer with in_last=1: go IDLE, ptr <= (lock_id+1) mod N.
  - LOCKED, no transfer: stay LOCKED. If in_valid[lock_id] drops, no other input is granted (bubble allowed).
  - LOCK_PKT=0: the FSM never leaves IDLE.
- Wrap-around: ptr wraps from N-1 to 0. With N=1, ptr stays 0 and out_src stays 0.
- Reset mid-packet: the packet is aborted and buffered beats are discarded. Recovery of the partial packet is the producer's responsibility.
- Arithmetic: ptr and lock_id are SRCW bits wide. Modulo-N increment is explicit, so non-power-of-2 N is correct.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  - function rr_next(ptr, N) for the modulo increment.
  - Parametrised typedef for the skid-buffer entry struct {data, last, src}.
- Sub-module skid_buffer_2 (DWIDTH+1+SRCW payload, valid/ready both sides, async active-low rst).
- The arbiter top holds the FSM, pointer, priority scan and input mux.

Test Plan:
- N=4, LOCK_PKT=1, out_ready=1, all inputs hold 1-beat packets (in_last=1), data=0x10+i -> out_src sequence 0,1,2,3,0,... with one beat per cycle after 1-cycle latency.
- N=4, input 1 sends a 3-beat packet (last on beat 3) while input 2 is valid throughout -> out_src=1,1,1 then 2; in_ready[2]=0 during the packet.
- Same stimulus with LOCK_PKT=0 -> out_src interleaves 1,2,1,2,1.
- out_ready=0 for 5 cycles with input 0 streaming -> exactly 2 beats accepted, then in_ready[0]=0. Release gives in-order output, no loss or duplication.
- N=3 (non-power-of-2), last grant=2, inputs 0 and 1 valid -> next grant=0; ptr never reaches 3.
- Assert rst=0 mid-packet while LOCKED on input 3 -> out_valid=0 immediately, FSM=IDLE, ptr=0. After release, the lowest valid index from 0 is granted.

Source files
------------

// File: rtl/arbiter_rr_pkt_n_pkg.sv
// Shared types and helpers for the packet-aware round-robin arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    // Explicit modulo-N increment so non-power-of-2 channel counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/arbiter_rr_pkt_n_skid.sv
// Two-entry output FIFO: registered upstream ready, head entry drives the outputs.
module skid_buffer_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Ready is a register so downstream ready never reaches the producers combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/arbiter_rr_pkt_n.sv
// N-input round-robin arbiter with optional packet locking and a registered 2-deep output.
module arbiter_rr_pkt_n
    import arb_pkg::*;
#(
    parameter int DWIDTH   = 20,
    parameter int N        = 2,
    parameter int LOCK_PKT = 1,
    parameter int SRCW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid [N],
    input  logic [DWIDTH-1:0] in_data  [N],
    input  logic              in_last  [N],
    output logic              in_ready [N],
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [SRCW-1:0]   out_src,
    input  logic              out_ready
);
    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
        logic [SRCW-1:0]   src;
    } entry_t;

    localparam int EW = $bits(entry_t);

    arb_state_t      state_q, state_d;
    logic [SRCW-1:0] ptr_q, ptr_d;
    logic [SRCW-1:0] lock_q, lock_d;
    logic [SRCW-1:0] scan_idx;
    logic [SRCW-1:0] grant;
    logic            scan_hit;
    logic            buf_ready;
    logic            xfer;
    int              scan_j;
    entry_t          push_entry;
    logic [EW-1:0]   head_bits;
    entry_t          head_entry;

    // Priority scan starting at ptr and wrapping past N-1 back to 0.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        scan_j   = 0;
        for (int k = 0; k < N; k++) begin
            scan_j = int'(ptr_q) + k;
            if (scan_j >= N) begin
                scan_j = scan_j - N;
            end
            if (!scan_hit && in_valid[scan_j]) begin
                scan_hit = 1'b1;
                scan_idx = SRCW'(scan_j);
            end
        end
    end

    assign grant = (state_q == ARB_LOCKED) ? lock_q : scan_idx;

    // While locked the owner sees ready even with valid low, so nobody else sneaks in.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = buf_ready & (grant == SRCW'(gi))
                                & ((state_q == ARB_LOCKED) | in_valid[gi]);
        end
    endgenerate

    assign xfer = in_valid[grant] & in_ready[grant];

    always_comb begin
        push_entry = '{data: in_data[grant], last: in_last[grant], src: grant};
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    if (LOCK_PKT == 0 || in_last[grant]) begin
                        ptr_d = SRCW'(rr_next(32'(grant), 32'(N)));
                    end else begin
                        state_d = ARB_LOCKED;
                        lock_d  = grant;
                    end
                end
            end
            ARB_LOCKED: begin
                if (xfer && in_last[grant]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = SRCW'(rr_next(32'(lock_q), 32'(N)));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    skid_buffer_2 #(.W(EW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (xfer),
        .in_ready  (buf_ready),
        .in_data   (push_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head_entry = head_bits;
    assign out_data   = head_entry.data;
    assign out_last   = head_entry.last;
    assign out_src    = head_entry.src;

endmodule

// File: tb/tb_arbiter_rr_pkt_n.sv
// Directed bench: three arbiter instances (N=4 locked, N=4 unlocked, N=3 locked).
module tb_arbiter_rr_pkt_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a_: N=4 LOCK_PKT=1
    logic        a_v [4];
    logic        a_l [4];
    logic        a_r [4];
    logic [19:0] a_d [4];
    logic        a_ov, a_ol, a_ordy;
    logic [19:0] a_od;
    logic [1:0]  a_os;
    // b_: N=4 LOCK_PKT=0
    logic        b_v [4];
    logic        b_l [4];
    logic        b_r [4];
    logic [19:0] b_d [4];
    logic        b_ov, b_ol, b_ordy;
    logic [19:0] b_od;
    logic [1:0]  b_os;
    // c_: N=3 LOCK_PKT=1
    logic        c_v [3];
    logic        c_l [3];
    logic        c_r [3];
    logic [19:0] c_d [3];
    logic        c_ov, c_ol, c_ordy;
    logic [19:0] c_od;
    logic [1:0]  c_os;

    arbiter_rr_pkt_n #(.DWIDTH(20), .N(4), .LOCK_PKT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_v), .in_data(a_d), .in_last(a_l), .in_ready(a_r),
        .out_valid(a_ov), .out_data(a_od), .out_last(a_ol), .out_src(a_os), .out_ready(a_ordy));
    arbiter_rr_pkt_n #(.DWIDTH(20), .N(4), .LOCK_PKT(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_v), .in_data(b_d), .in_last(b_l), .in_ready(b_r),
        .out_valid(b_ov), .out_data(b_od), .out_last(b_ol), .out_src(b_os), .out_ready(b_ordy));
    arbiter_rr_pkt_n #(.DWIDTH(20), .N(3), .LOCK_PKT(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_v), .in_data(c_d), .in_last(c_l), .in_ready(c_r),
        .out_valid(c_ov), .out_data(c_od), .out_last(c_ol), .out_src(c_os), .out_ready(c_ordy));

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 1'b1; a_l[i] = 1'b1; a_d[i] = 20'h10 + 20'(i);
            b_v[i] = 1'b0; b_l[i] = 1'b0; b_d[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            c_v[i] = 1'b0; c_l[i] = 1'b0; c_d[i] = '0;
        end
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_ov); end
        checks++; if (a_od !== 20'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", a_od); end
        checks++; if (a_ol !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", a_ol); end
        checks++; if (a_os !== 2'd0) begin failures++; $display("FAIL reset_out_src got=%0d exp=0", a_os); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_r[i] !== 1'b0) begin failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=0", i, a_r[i]); end
        end
        checks++; if (b_ov !== 1'b0 || c_ov !== 1'b0) begin failures++; $display("FAIL reset_other_valid got=%b%b exp=00", b_ov, c_ov); end
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_r[i] !== (i == 0)) begin failures++; $display("FAIL rr_first_ready[%0d] got=%b exp=%b", i, a_r[i], i == 0); end
        end
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL rr_latency got=%b exp=0", a_ov); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            $display("rr beat %0d: valid=%b src=%0d data=%h", c, a_ov, a_os, a_od);
            checks++; if (a_ov !== 1'b1 || a_os !== 2'(c % 4) || a_od !== 20'h10 + 20'(c % 4))
                begin failures++; $display("FAIL rr_seq beat=%0d got=%b/%0d/%h exp=1/%0d/%h", c, a_ov, a_os, a_od, c % 4, 16 + c % 4); end
        end
        for (int i = 0; i < 4; i++) a_v[i] = 1'b0;
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_lock_pkt();
        a_v[1] = 1'b1; a_l[1] = 1'b0; a_d[1] = 20'hA1;
        a_v[2] = 1'b1; a_l[2] = 1'b1; a_d[2] = 20'hB1;
        #1;
        checks++; if (a_r[1] !== 1'b1 || a_r[2] !== 1'b0) begin failures++; $display("FAIL lock_start got=%b%b exp=10", a_r[1], a_r[2]); end
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            $display("lock beat %0d: src=%0d data=%h last=%b", b, a_os, a_od, a_ol);
            checks++; if (a_ov !== 1'b1 || a_os !== 2'd1 || a_od !== 20'hA0 + 20'(b) || a_ol !== (b == 3))
                begin failures++; $display("FAIL lock_beat%0d got=%b/%0d/%h/%b exp=1/1/%h/%b", b, a_ov, a_os, a_od, a_ol, 160 + b, b == 3); end
            if (b < 3) begin
                a_d[1] = 20'hA1 + 20'(b); a_l[1] = (b == 2);
                #1;
                checks++; if (a_r[2] !== 1'b0 || a_r[1] !== 1'b1) begin failures++; $display("FAIL lock_hold beat=%0d got=%b%b exp=10", b, a_r[1], a_r[2]); end
            end else begin
                a_v[1] = 1'b0;
                #1;
                checks++; if (a_r[2] !== 1'b1) begin failures++; $display("FAIL lock_release got=%b exp=1", a_r[2]); end
            end
        end
        @(negedge clk);
        checks++; if (a_os !== 2'd2 || a_od !== 20'hB1 || a_ol !== 1'b1) begin failures++; $display("FAIL lock_next got=%0d/%h exp=2/b1", a_os, a_od); end
        a_v[2] = 1'b0;
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL lock_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_no_lock();
        logic [1:0]  exp_src [6];
        logic [19:0] exp_dat [6];
        exp_src = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        exp_dat = '{20'hA1, 20'hB1, 20'hA2, 20'hB2, 20'hA3, 20'hB3};
        b_v[1] = 1'b1; b_l[1] = 1'b0; b_d[1] = 20'hA1;
        b_v[2] = 1'b1; b_l[2] = 1'b1; b_d[2] = 20'hB1;
        #1;
        checks++; if (b_r[1] !== 1'b1 || b_r[2] !== 1'b0) begin failures++; $display("FAIL nolock_start got=%b%b exp=10", b_r[1], b_r[2]); end
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            $display("nolock beat %0d: src=%0d data=%h", s, b_os, b_od);
            checks++; if (b_ov !== 1'b1 || b_os !== exp_src[s] || b_od !== exp_dat[s])
                begin failures++; $display("FAIL nolock_seq beat=%0d got=%0d/%h exp=%0d/%h", s, b_os, b_od, exp_src[s], exp_dat[s]); end
            case (s)
                0: b_d[1] = 20'hA2;
                1: b_d[2] = 20'hB2;
                2: begin b_d[1] = 20'hA3; b_l[1] = 1'b1; end
                3: b_d[2] = 20'hB3;
                4: b_v[1] = 1'b0;
                default: b_v[2] = 1'b0;
            endcase
        end
        @(negedge clk);
        checks++; if (b_ov !== 1'b0) begin failures++; $display("FAIL nolock_drain got=%b exp=0", b_ov); end
    endtask

    task automatic test_backpressure();
        a_ordy = 1'b0;
        a_v[0] = 1'b1; a_l[0] = 1'b1; a_d[0] = 20'h100;
        #1;
        checks++; if (a_r[0] !== 1'b1) begin failures++; $display("FAIL bp_start got=%b exp=1", a_r[0]); end
        @(negedge clk);
        checks++; if (a_ov !== 1'b1 || a_od !== 20'h100) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/100", a_ov, a_od); end
        a_d[0] = 20'h101;
        #1;
        checks++; if (a_r[0] !== 1'b1) begin failures++; $display("FAIL bp_second_ready got=%b exp=1", a_r[0]); end
        @(negedge clk);
        a_d[0] = 20'h102;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge clk);
            $display("bp stall %0d: in_ready=%b head=%h", s, a_r[0], a_od);
            checks++; if (a_r[0] !== 1'b0 || a_od !== 20'h100) begin failures++; $display("FAIL bp_full step=%0d got=%b/%h exp=0/100", s, a_r[0], a_od); end
        end
        a_ordy = 1'b1;
        @(negedge clk);
        checks++; if (a_ov !== 1'b1 || a_od !== 20'h101 || a_r[0] !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%h/%b exp=1/101/1", a_ov, a_od, a_r[0]); end
        @(negedge clk);
        checks++; if (a_ov !== 1'b1 || a_od !== 20'h102) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/102", a_ov, a_od); end
        a_v[0] = 1'b0;
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", a_ov); end
    endtask

    task automatic test_n3_wrap();
        logic [1:0] exp_src [6];
        exp_src = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        c_v[2] = 1'b1; c_l[2] = 1'b1; c_d[2] = 20'h32;
        c_l[0] = 1'b1; c_d[0] = 20'h30; c_l[1] = 1'b1; c_d[1] = 20'h31;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            $display("n3 beat %0d: src=%0d data=%h", s, c_os, c_od);
            checks++; if (c_ov !== 1'b1 || c_os !== exp_src[s] || c_od !== 20'h30 + 20'(exp_src[s]))
                begin failures++; $display("FAIL n3_seq beat=%0d got=%0d/%h exp=%0d", s, c_os, c_od, exp_src[s]); end
            case (s)
                0: begin c_v[2] = 1'b0; c_v[0] = 1'b1; c_v[1] = 1'b1; end
                1: c_v[0] = 1'b0;
                2: begin c_v[0] = 1'b1; c_v[1] = 1'b1; c_v[2] = 1'b1; end
                5: begin c_v[0] = 1'b0; c_v[1] = 1'b0; c_v[2] = 1'b0; end
                default: ;
            endcase
        end
        @(negedge clk);
        checks++; if (c_ov !== 1'b0) begin failures++; $display("FAIL n3_drain got=%b exp=0", c_ov); end
    endtask

    task automatic test_reset_mid_packet();
        a_v[3] = 1'b1; a_l[3] = 1'b0; a_d[3] = 20'h300;
        #1;
        checks++; if (a_r[3] !== 1'b1) begin failures++; $display("FAIL mid_lock_start got=%b exp=1", a_r[3]); end
        @(negedge clk);
        checks++; if (a_os !== 2'd3 || a_od !== 20'h300) begin failures++; $display("FAIL mid_first got=%0d/%h exp=3/300", a_os, a_od); end
        a_d[3] = 20'h301; a_ordy = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        a_v[0] = 1'b1; a_l[0] = 1'b1; a_d[0] = 20'h400;
        a_v[2] = 1'b1; a_l[2] = 1'b1; a_d[2] = 20'h402;
        a_l[3] = 1'b1; a_d[3] = 20'h303;
        a_ordy = 1'b1;
        #1;
        checks++; if (a_ov !== 1'b0 || a_od !== 20'h0 || a_os !== 2'd0) begin failures++; $display("FAIL mid_async_reset got=%b/%h/%0d exp=0/0/0", a_ov, a_od, a_os); end
        checks++; if (a_r[0] !== 1'b0 || a_r[2] !== 1'b0 || a_r[3] !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b%b%b exp=000", a_r[0], a_r[2], a_r[3]); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_r[0] !== 1'b1 || a_r[2] !== 1'b0 || a_r[3] !== 1'b0) begin failures++; $display("FAIL mid_regrant got=%b%b%b exp=100", a_r[0], a_r[2], a_r[3]); end
        @(negedge clk);
        $display("mid recovery: src=%0d data=%h", a_os, a_od);
        checks++; if (a_ov !== 1'b1 || a_os !== 2'd0 || a_od !== 20'h400) begin failures++; $display("FAIL mid_recover got=%b/%0d/%h exp=1/0/400", a_ov, a_os, a_od); end
        for (int i = 0; i < 4; i++) a_v[i] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_pkt();
        test_no_lock();
        test_backpressure();
        test_n3_wrap();
        test_reset_mid_packet();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
